// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
//
// Board-level reset sequencer for the E203 FPGA system top. It debounces the
// external reset button, holds the MMCM in reset, waits for a stable lock, and
// then releases the peripheral reset and the SoC external reset
// (io_pads_aon_erst_n_i_ival) in a fixed order. A debounced button press, or
// lock loss, re-sequences the board.
//
// Optional feature macro: RST_SEQ_WDT_EN
//   defined   : WAIT_LOCK runs a 16-bit watchdog. When it expires, the sticky
//               timeout_o flag is set and the MMCM reset is pulsed again via
//               HOLD.
//   undefined : WAIT_LOCK waits indefinitely; timeout_o is tied low.
//
// Ports
//   clk            in  1  free-running board clock, the only clock
//   reset          in  1  synchronous, active-high
//   btn_rst_n_i    in  1  raw reset button, asynchronous, active-low
//   mmcm_locked_i  in  1  MMCM lock, asynchronous
//   mmcm_resetn_o  out 1  MMCM reset, active-low
//   periph_reset_o out 1  peripheral reset, active-high
//   soc_erst_n_o   out 1  SoC external reset, active-low
//   state_o        out 3  HOLD=0, WAIT_LOCK=1, PERIPH_REL=2, RUN=3
//   lock_lost_o    out 1  one-cycle pulse when lock is lost in PERIPH_REL/RUN
//   timeout_o      out 1  sticky lock-timeout flag
// -----------------------------------------------------------------------------
module rst_seq_ctrl #(
  parameter int DEBOUNCE_CYCLES  = 1000000,
  parameter int HOLD_MIN_CYCLES  = 16,
  parameter int LOCK_WAIT_CYCLES = 1024,
  parameter int SOC_HOLD_CYCLES  = 4096,
  parameter int CNT_W            = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_rst_n_i,
  input  logic       mmcm_locked_i,
  output logic       mmcm_resetn_o,
  output logic       periph_reset_o,
  output logic       soc_erst_n_o,
  output logic [2:0] state_o,
  output logic       lock_lost_o,
  output logic       timeout_o
);

  typedef enum logic [2:0] {
    ST_HOLD       = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_PERIPH_REL = 3'd2,
    ST_RUN        = 3'd3
  } state_t;

  // Terminal counts, sized to the shared counter width.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOC_LAST  = CNT_W'(SOC_HOLD_CYCLES - 1);

  // Output pattern per state, packed as {mmcm_resetn, periph_reset, soc_erst_n}.
  function automatic logic [2:0] f_outs(input state_t s);
    logic [2:0] v;
    v = 3'b010;
    case (s)
      ST_HOLD:       v = 3'b010;
      ST_WAIT_LOCK:  v = 3'b110;
      ST_PERIPH_REL: v = 3'b100;
      ST_RUN:        v = 3'b101;
      default:       v = 3'b010;
    endcase
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers: bit 0 = button, bit 1 = lock. Both flops reset to 0
  // so that, straight out of reset, the button looks pressed and the MMCM looks
  // unlocked until the real pin levels have propagated.
  // ---------------------------------------------------------------------------
  logic [1:0] w_async;
  logic [1:0] w_sync;

  assign w_async = {mmcm_locked_i, btn_rst_n_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic r_meta;
      logic r_out;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_meta <= 1'b0;
          r_out  <= 1'b0;
        end else begin
          r_meta <= w_async[gi];
          r_out  <= r_meta;
        end
      end

      assign w_sync[gi] = r_out;
    end
  endgenerate

  logic w_btn_s;
  logic w_lock_s;

  assign w_btn_s  = w_sync[0];
  assign w_lock_s = w_sync[1];

  // ---------------------------------------------------------------------------
  // Button debouncer. The counter only runs while the synchronised sample
  // disagrees with the debounced level; any agreeing sample restarts it. The
  // debounced level flips one edge after the counter reaches its last value.
  // ---------------------------------------------------------------------------
  logic             r_btn_db;
  logic [CNT_W-1:0] r_db_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_db <= 1'b0;
      r_db_cnt <= '0;
    end else if (w_btn_s == r_btn_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_btn_db <= ~r_btn_db;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM. State, shared counter and all outputs are registered in one
  // block, so the outputs change on the same edge as the state register.
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_outs;
  logic             r_lock_lost;

`ifdef RST_SEQ_WDT_EN
  logic [15:0] r_wdt;
  logic        r_timeout;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_HOLD;
      r_cnt       <= '0;
      r_outs      <= f_outs(ST_HOLD);
      r_lock_lost <= 1'b0;
`ifdef RST_SEQ_WDT_EN
      r_wdt       <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_lock_lost <= 1'b0;

`ifdef RST_SEQ_WDT_EN
      // Watchdog free-runs only while in WAIT_LOCK, so it is always zero on
      // entry to WAIT_LOCK. Wrapping at expiry is harmless: the state leaves.
      if (r_state == ST_WAIT_LOCK) begin
        r_wdt <= r_wdt + 1'b1;
      end else begin
        r_wdt <= '0;
      end
`endif

      // A debounced press wins over everything else, including lock loss,
      // which is why lock_lost_o stays quiet when both happen together.
      if (!r_btn_db && (r_state != ST_HOLD)) begin
        r_state <= ST_HOLD;
        r_outs  <= f_outs(ST_HOLD);
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_HOLD: begin
            // The counter saturates at the minimum pulse width, so a long
            // button hold cannot wrap it around.
            if (r_btn_db && (r_cnt >= HOLD_LAST)) begin
              r_state <= ST_WAIT_LOCK;
              r_outs  <= f_outs(ST_WAIT_LOCK);
              r_cnt   <= '0;
            end else if (r_cnt < HOLD_LAST) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          ST_WAIT_LOCK: begin
`ifdef RST_SEQ_WDT_EN
            if (r_wdt == 16'hFFFF) begin
              r_state   <= ST_HOLD;
              r_outs    <= f_outs(ST_HOLD);
              r_cnt     <= '0;
              r_timeout <= 1'b1;
            end else
`endif
            // r_cnt counts consecutive high lock samples; one low sample
            // restarts the qualification window.
            if (w_lock_s && (r_cnt == LOCK_LAST)) begin
              r_state <= ST_PERIPH_REL;
              r_outs  <= f_outs(ST_PERIPH_REL);
              r_cnt   <= '0;
            end else if (w_lock_s) begin
              r_cnt <= r_cnt + 1'b1;
            end else begin
              r_cnt <= '0;
            end
          end

          ST_PERIPH_REL: begin
            if (!w_lock_s) begin
              r_state     <= ST_WAIT_LOCK;
              r_outs      <= f_outs(ST_WAIT_LOCK);
              r_cnt       <= '0;
              r_lock_lost <= 1'b1;
            end else if (r_cnt == SOC_LAST) begin
              r_state <= ST_RUN;
              r_outs  <= f_outs(ST_RUN);
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          ST_RUN: begin
            // Peripheral and SoC resets reassert together on this one edge.
            if (!w_lock_s) begin
              r_state     <= ST_WAIT_LOCK;
              r_outs      <= f_outs(ST_WAIT_LOCK);
              r_cnt       <= '0;
              r_lock_lost <= 1'b1;
            end
          end

          default: begin
            r_state <= ST_HOLD;
            r_outs  <= f_outs(ST_HOLD);
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign mmcm_resetn_o  = r_outs[2];
  assign periph_reset_o = r_outs[1];
  assign soc_erst_n_o   = r_outs[0];
  assign state_o        = r_state;
  assign lock_lost_o    = r_lock_lost;

`ifdef RST_SEQ_WDT_EN
  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Board-level reset sequencer for the E203 FPGA system top. It sits upstream of the clock manager, the reset synchroniser and the SoC AON reset pad. It debounces the external reset button, holds the MMCM in reset, and waits for a stable lock. It then releases peripheral reset and the SoC external reset (`io_pads_aon_erst_n_i_ival`) in a fixed order, and re-sequences on button press or lock loss.

## Interface
- `DEBOUNCE_CYCLES`, 1000000: consecutive identical button samples needed to change the debounced state (10 ms at 100 MHz).
- `HOLD_MIN_CYCLES`, 16: minimum HOLD duration; this is the MMCM reset pulse width.
- `LOCK_WAIT_CYCLES`, 1024: consecutive cycles `locked` must be high before peripheral release.
- `SOC_HOLD_CYCLES`, 4096: cycles between peripheral release and SoC release.
- `CNT_W`, 20: width of the shared counters; must hold every count parameter minus 1.
- `clk` input 1: free-running board clock (CLK100MHZ). This is the only clock.
- `reset` input 1: synchronous, active-high.
- `btn_rst_n_i` input 1: asynchronous raw button, active-low.
- `mmcm_locked_i` input 1: asynchronous MMCM lock.
- `mmcm_resetn_o` output 1: MMCM reset, active-low.
- `periph_reset_o` output 1: peripheral reset, active-high.
- `soc_erst_n_o` output 1: SoC external reset, active-low.
- `state_o` output 3: current state encoding (HOLD=0, WAIT_LOCK=1, PERIPH_REL=2, RUN=3).
- `lock_lost_o` output 1: single-cycle pulse on lock loss.
- `timeout_o` output 1: sticky lock-timeout flag.

## Operation
- Synchronisers:
  - `btn_rst_n_i` and `mmcm_locked_i` each pass through a 2-flop synchroniser, producing `btn_s` and `lock_s`.
  - Both synchroniser flops reset to 0.
- Debouncer:
  - `btn_db` resets to 0, meaning pressed.
  - The counter clears whenever `btn_s == btn_db`; otherwise it increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while still differing, `btn_db` toggles on the next edge and the counter clears.
- Outputs are registered and updated on the same edge as the state register.

| State | `mmcm_resetn_o` | `periph_reset_o` | `soc_erst_n_o` |
|---|---|---|---|
| HOLD | 0 | 1 | 0 |
| WAIT_LOCK | 1 | 1 | 0 |
| PERIPH_REL | 1 | 0 | 0 |
| RUN | 1 | 0 | 1 |

- State transitions. The counter clears on every state change.
  - HOLD -> WAIT_LOCK: `btn_db == 1` and at least `HOLD_MIN_CYCLES` cycles have been spent in HOLD.
  - WAIT_LOCK -> PERIPH_REL: `lock_s` has been high for `LOCK_WAIT_CYCLES` consecutive cycles. Any low sample of `lock_s` clears the count.
  - PERIPH_REL -> RUN: after `SOC_HOLD_CYCLES` cycles in PERIPH_REL.
  - PERIPH_REL or RUN -> WAIT_LOCK: `lock_s == 0`. `lock_lost_o` pulses for 1 cycle.
  - Any state -> HOLD: `btn_db == 0`. This has highest priority; `lock_lost_o` does not pulse if both events occur in the same cycle.
- Reset:
  - Reset values: state HOLD, counters 0, `btn_db` 0, `timeout_o` 0, `lock_lost_o` 0, and all outputs at their HOLD values.
  - Reset asserted mid-sequence forces HOLD values on the next edge.

## Timing
- Button release to WAIT_LOCK: 2 synchroniser cycles, plus `DEBOUNCE_CYCLES` debounce cycles, plus 1 transition cycle.
- Button press to HOLD: 2 + `DEBOUNCE_CYCLES` + 1 cycles.
- With `lock_s` steady high:
  - `periph_reset_o` falls exactly `LOCK_WAIT_CYCLES` cycles after `mmcm_resetn_o` rises.
  - `soc_erst_n_o` rises `SOC_HOLD_CYCLES` cycles after that.
- Lock drop on the pin to output reassertion: 2 synchroniser cycles + 1 cycle.
- Release order is always MMCM, then peripheral, then SoC. Reassertion of periph/SoC is simultaneous, on one edge.

## Configuration
- `RST_SEQ_WDT_EN` defined:
  - WAIT_LOCK runs a separate 16-bit timeout counter, incremented every cycle while in WAIT_LOCK.
  - On reaching 65535 the block sets `timeout_o` and enters HOLD, which re-pulses the MMCM reset for `HOLD_MIN_CYCLES`, then retries.
  - `timeout_o` clears only on `reset`.
- `RST_SEQ_WDT_EN` undefined:
  - No timeout counter; WAIT_LOCK waits indefinitely.
  - `timeout_o` is tied to 0.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=8, `HOLD_MIN_CYCLES`=4, `LOCK_WAIT_CYCLES`=4, `SOC_HOLD_CYCLES`=6.

- **Power-up:** reset for 3 cycles with button high and locked high. Expect:
  - `mmcm_resetn_o` rises 11 cycles after reset deasserts.
  - `periph_reset_o` falls 4 cycles later.
  - `soc_erst_n_o` rises 6 cycles after that.
- **Button bounce:** in RUN, pulse `btn_rst_n_i` low for 5 cycles, 3 times. Expect the state to stay RUN and `soc_erst_n_o` to stay 1.
- **Button press:** in RUN, hold `btn_rst_n_i` low for 20 cycles. Expect:
  - HOLD outputs 11 cycles after the falling edge.
  - Re-sequence after release.
- **Lock glitch:** in WAIT_LOCK, drop locked for 1 cycle at count 3. Expect the count to restart, so PERIPH_REL is entered 4 full cycles after lock returns.
- **Lock loss in RUN:** drop locked. Expect:
  - `lock_lost_o` pulses once after 3 cycles.
  - `periph_reset_o`=1 and `soc_erst_n_o`=0 on the same edge.
  - State is WAIT_LOCK.
- **Lock timeout (`RST_SEQ_WDT_EN`):** hold locked low. Expect:
  - After 65536 cycles in WAIT_LOCK, `timeout_o`=1.
  - HOLD for 4 cycles with `mmcm_resetn_o`=0, then back to WAIT_LOCK.
